// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: hazard/execute controls in, IF/ID register and PC out.
// The fetch stage takes the master side; the surrounding pipeline the slave.
interface fetch_stage_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic        PcOpE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  modport master (
    input  StallF, StallD, FlushD,
    input  PCSrcE, PcOpE,
    input  PCTargetE, ALUResultE,
    input  InstrF,
    output PCF, InstrD, PCD,
    output PCPlus4D, ValidD
  );

  modport slave (
    output StallF, StallD, FlushD,
    output PCSrcE, PcOpE,
    output PCTargetE, ALUResultE,
    output InstrF,
    input  PCF, InstrD, PCD,
    input  PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect mux and IF/ID pipeline register.
// PCF comes straight from the PC flop; a redirect flushes decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  fif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       32'd0,
    pc_plus4: 32'd0,
    valid:    1'b0
  };

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] pc_next;
  if_id_t      id_q;
  if_id_t      id_next;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    target   = fif.PcOpE
             ? {fif.ALUResultE[31:1], 1'b0}
             : fif.PCTargetE;
  end

  // Redirect beats stall so a taken branch is never lost.
  always_comb begin
    pc_next = pc_plus4;
    if (fif.PCSrcE)
      pc_next = target;
    else if (fif.StallF)
      pc_next = pc_q;
  end

  always_comb begin
    id_next = id_q;
    if (fif.FlushD || fif.PCSrcE)
      id_next = BUBBLE;
    else if (!fif.StallD)
      id_next = '{
        instr:    fif.InstrF,
        pc:       pc_q,
        pc_plus4: pc_plus4,
        valid:    1'b1
      };
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      id_q <= BUBBLE;
    end else begin
      pc_q <= pc_next;
      id_q <= id_next;
    end
  end

  assign fif.PCF      = pc_q;
  assign fif.InstrD   = id_q.instr;
  assign fif.PCD      = id_q.pc;
  assign fif.PCPlus4D = id_q.pc_plus4;
  assign fif.ValidD   = id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequencing, redirects,
// stalls, flush priority, PC wrap and asynchronous reset.
module tb_fetch_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic        use_ovr;
  logic [31:0] ovr;

  localparam logic [31:0] NOP = 32'h00000013;

  fetch_stage_if fif ();

  fetch_stage #(
    .RESET_PC  (32'hBFC00000),
    .NOP_INSTR (32'h00000013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hA5A50F0F;
  endfunction

  always_comb fif.InstrF = use_ovr ? ovr : imem(fif.PCF);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    fif.StallF     = 1'b0;
    fif.StallD     = 1'b0;
    fif.FlushD     = 1'b0;
    fif.PCSrcE     = 1'b0;
    fif.PcOpE      = 1'b0;
    fif.PCTargetE  = 32'h0;
    fif.ALUResultE = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (fif.PCF !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc got %h want %h", fif.PCF, 32'hBFC00000); end
    checks++; if (fif.ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fif.ValidD); end
    checks++; if (fif.InstrD !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", fif.InstrD, NOP); end
    step();
    checks++; if (fif.PCF !== 32'hBFC00000) begin errors++; $display("FAIL reset_hold_pc got %h want %h", fif.PCF, 32'hBFC00000); end
    checks++; if (fif.PCD !== 32'h0 || fif.PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcd got %h/%h want 0/0", fif.PCD, fif.PCPlus4D); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'hBFC00000;
    checks++; if (fif.ValidD !== 1'b0) begin errors++; $display("FAIL seq_valid0 got %b want 0", fif.ValidD); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (fif.PCF !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pcf[%0d] got %h want %h", i, fif.PCF, exp_pc + 32'd4); end
      checks++; if (fif.PCD !== exp_pc) begin errors++; $display("FAIL seq_pcd[%0d] got %h want %h", i, fif.PCD, exp_pc); end
      checks++; if (fif.InstrD !== imem(exp_pc)) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, fif.InstrD, imem(exp_pc)); end
      checks++; if (fif.PCPlus4D !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc4[%0d] got %h want %h", i, fif.PCPlus4D, exp_pc + 32'd4); end
      checks++; if (fif.ValidD !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, fif.ValidD); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    fif.PCSrcE    = 1'b1;
    fif.PcOpE     = 1'b0;
    fif.PCTargetE = 32'hBFC00040;
    fif.ALUResultE = 32'h11111111;
    fif.StallF    = 1'b1;
    step();
    clear_ctl();
    checks++; if (fif.PCF !== 32'hBFC00040) begin errors++; $display("FAIL br_pcf got %h want %h", fif.PCF, 32'hBFC00040); end
    checks++; if (fif.InstrD !== NOP || fif.ValidD !== 1'b0) begin errors++; $display("FAIL br_bubble got %h/%b want %h/0", fif.InstrD, fif.ValidD, NOP); end
    checks++; if (fif.PCD !== 32'h0) begin errors++; $display("FAIL br_pcd got %h want 0", fif.PCD); end
    step();
    checks++; if (fif.InstrD !== imem(32'hBFC00040) || fif.PCD !== 32'hBFC00040) begin errors++; $display("FAIL br_target_dec got %h/%h want %h/%h", fif.InstrD, fif.PCD, imem(32'hBFC00040), 32'hBFC00040); end
    checks++; if (fif.PCF !== 32'hBFC00044) begin errors++; $display("FAIL br_next got %h want %h", fif.PCF, 32'hBFC00044); end
  endtask

  task automatic test_jalr();
    fif.PCSrcE     = 1'b1;
    fif.PcOpE      = 1'b1;
    fif.ALUResultE = 32'hBFC00101;
    fif.PCTargetE  = 32'h12345678;
    step();
    clear_ctl();
    checks++; if (fif.PCF !== 32'hBFC00100) begin errors++; $display("FAIL jalr_pcf got %h want %h", fif.PCF, 32'hBFC00100); end
    checks++; if (fif.ValidD !== 1'b0 || fif.InstrD !== NOP) begin errors++; $display("FAIL jalr_bubble got %h/%b want %h/0", fif.InstrD, fif.ValidD, NOP); end
  endtask

  task automatic test_stall();
    step();
    fif.StallF = 1'b1;
    fif.StallD = 1'b1;
    use_ovr    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ovr = 32'hDEAD0000 + 32'(i);
      step();
      checks++; if (fif.PCF !== 32'hBFC00104) begin errors++; $display("FAIL stall_pcf[%0d] got %h want %h", i, fif.PCF, 32'hBFC00104); end
      checks++; if (fif.InstrD !== imem(32'hBFC00100) || fif.PCD !== 32'hBFC00100) begin errors++; $display("FAIL stall_dec[%0d] got %h/%h want %h/%h", i, fif.InstrD, fif.PCD, imem(32'hBFC00100), 32'hBFC00100); end
    end
    use_ovr = 1'b0;
    clear_ctl();
    step();
    checks++; if (fif.PCD !== 32'hBFC00104 || fif.InstrD !== imem(32'hBFC00104)) begin errors++; $display("FAIL stall_release got %h/%h want %h/%h", fif.PCD, fif.InstrD, 32'hBFC00104, imem(32'hBFC00104)); end
    checks++; if (fif.PCF !== 32'hBFC00108) begin errors++; $display("FAIL stall_resume got %h want %h", fif.PCF, 32'hBFC00108); end
  endtask

  task automatic test_flush_stall();
    fif.FlushD = 1'b1;
    fif.StallD = 1'b1;
    fif.StallF = 1'b1;
    step();
    clear_ctl();
    checks++; if (fif.ValidD !== 1'b0 || fif.InstrD !== NOP) begin errors++; $display("FAIL flush_wins got %h/%b want %h/0", fif.InstrD, fif.ValidD, NOP); end
    checks++; if (fif.PCF !== 32'hBFC00108) begin errors++; $display("FAIL flush_pcf got %h want %h", fif.PCF, 32'hBFC00108); end
  endtask

  task automatic test_wrap();
    fif.PCSrcE    = 1'b1;
    fif.PCTargetE = 32'hFFFFFFFC;
    step();
    clear_ctl();
    checks++; if (fif.PCF !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_set got %h want %h", fif.PCF, 32'hFFFFFFFC); end
    step();
    checks++; if (fif.PCF !== 32'h0) begin errors++; $display("FAIL wrap_pcf got %h want 0", fif.PCF); end
    checks++; if (fif.PCPlus4D !== 32'h0 || fif.PCD !== 32'hFFFFFFFC || fif.ValidD !== 1'b1) begin errors++; $display("FAIL wrap_dec got %h/%h/%b want 0/fffffffc/1", fif.PCPlus4D, fif.PCD, fif.ValidD); end
  endtask

  task automatic test_illegal_stall();
    fif.StallD = 1'b1;
    step();
    clear_ctl();
    checks++; if (fif.PCF !== 32'h4) begin errors++; $display("FAIL ill_pcf got %h want 4", fif.PCF); end
    checks++; if (fif.PCD !== 32'hFFFFFFFC || fif.InstrD !== imem(32'hFFFFFFFC)) begin errors++; $display("FAIL ill_dec got %h/%h want fffffffc/%h", fif.PCD, fif.InstrD, imem(32'hFFFFFFFC)); end
  endtask

  task automatic test_reset_mid();
    fif.StallF    = 1'b1;
    fif.StallD    = 1'b1;
    step();
    fif.PCSrcE    = 1'b1;
    fif.PCTargetE = 32'h00000800;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fif.PCF !== 32'hBFC00000) begin errors++; $display("FAIL rstmid_pcf got %h want %h", fif.PCF, 32'hBFC00000); end
    checks++; if (fif.ValidD !== 1'b0 || fif.PCD !== 32'h0) begin errors++; $display("FAIL rstmid_dec got %b/%h want 0/0", fif.ValidD, fif.PCD); end
    step();
    rst = 1'b0;
    clear_ctl();
    step();
    checks++; if (fif.PCF !== 32'hBFC00004) begin errors++; $display("FAIL rstmid_resume got %h want %h", fif.PCF, 32'hBFC00004); end
    checks++; if (fif.PCD !== 32'hBFC00000 || fif.ValidD !== 1'b1) begin errors++; $display("FAIL rstmid_first got %h/%b want %h/1", fif.PCD, fif.ValidD, 32'hBFC00000); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    use_ovr = 1'b0;
    ovr     = 32'h0;
    clear_ctl();
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall();
    test_flush_stall();
    test_wrap();
    test_illegal_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
